// File: rtl/ternary_matvec_stream_if.sv
// Handshake bundle for the streaming ternary matrix-vector engine:
// beat input channel (vector lanes + weight rows) and element output channel.
interface ternary_matvec_stream_if #(
  parameter int OutLen   = 7,
  parameter int BitWidth = 8,
  parameter int Lanes    = 2
);
  logic                          in_valid;
  logic                          in_ready;
  logic [Lanes*BitWidth-1:0]     vec_in;
  logic [2*Lanes*OutLen-1:0]     w_in;
  logic                          sat_en;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [BitWidth-1:0]    vec_out;
  logic                          out_last;
  logic                          out_sat;

  modport master (
    output in_valid, vec_in, w_in, sat_en, out_ready,
    input  in_ready, out_valid, vec_out, out_last, out_sat
  );

  modport slave (
    input  in_valid, vec_in, w_in, sat_en, out_ready,
    output in_ready, out_valid, vec_out, out_last, out_sat
  );
endinterface

// File: rtl/ternary_matvec_stream.sv
// Streaming ternary matrix-vector engine: accumulates OutLen column sums over
// InLen/Lanes beats, then serialises clipped results one element per cycle.
module ternary_matvec_stream #(
  parameter int InLen    = 14,
  parameter int OutLen   = 7,
  parameter int BitWidth = 8,
  parameter int Lanes    = 2,
  parameter int AccWidth = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  ternary_matvec_stream_if.slave bus
);
  localparam int Beats = InLen / Lanes;
  localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int IdxW  = (OutLen > 1) ? $clog2(OutLen) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(OutLen - 1);
  localparam logic signed [AccWidth-1:0] MaxV =
    {{(AccWidth-BitWidth+1){1'b0}}, {(BitWidth-1){1'b1}}};
  localparam logic signed [AccWidth-1:0] MinV =
    {{(AccWidth-BitWidth+1){1'b1}}, {(BitWidth-1){1'b0}}};

  generate
    if (InLen % Lanes != 0) begin : g_bad_lanes
      $error("InLen must be a multiple of Lanes");
    end
    if (AccWidth < BitWidth + $clog2(InLen + 1)) begin : g_bad_acc
      $error("AccWidth too narrow for InLen full-scale sums");
    end
  endgenerate

  // Input is widened before negation so that -(most negative) is exact.
  function automatic logic signed [AccWidth-1:0] ternary_term(
    input logic [1:0] code, input logic signed [BitWidth-1:0] x);
    logic signed [AccWidth-1:0] xe;
    xe = x;
    case (code)
      2'b01:   ternary_term = xe;
      2'b11:   ternary_term = -xe;
      default: ternary_term = '0;
    endcase
  endfunction

  function automatic logic out_of_range(input logic signed [AccWidth-1:0] a);
    return (a > MaxV) || (a < MinV);
  endfunction

  function automatic logic signed [BitWidth-1:0] clip(
    input logic signed [AccWidth-1:0] a, input logic sat);
    if (sat && (a > MaxV))      return MaxV[BitWidth-1:0];
    else if (sat && (a < MinV)) return MinV[BitWidth-1:0];
    else                        return a[BitWidth-1:0];
  endfunction

  typedef enum logic {EMPTY, DRAIN} state_t;

  state_t                       state, state_n;
  logic [IdxW-1:0]              idx, idx_n;
  logic [BeatW-1:0]             beat;
  logic                         last_beat, in_fire, out_fire, load, last_n;
  logic signed [AccWidth-1:0]   acc_p0 [OutLen];
  logic signed [AccWidth-1:0]   sum_p0 [OutLen];
  logic signed [BitWidth-1:0]   obuf_p1 [OutLen];
  logic                         obuf_sat_p1 [OutLen];
  logic                         out_last_p1;

  assign last_beat     = (beat == LastBeat);
  assign bus.out_valid = (state == DRAIN);
  assign out_fire      = bus.out_valid && bus.out_ready;
  assign bus.in_ready  = !(last_beat && (state == DRAIN) && !(out_fire && out_last_p1));
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign load          = in_fire && last_beat;
  assign bus.vec_out   = obuf_p1[0];
  assign bus.out_sat   = obuf_sat_p1[0];
  assign bus.out_last  = out_last_p1;

  // ---- stage p0: beat contribution onto running column sums
  always_comb begin
    for (int j = 0; j < OutLen; j++) begin
      sum_p0[j] = (beat == '0) ? '0 : acc_p0[j];
      for (int k = 0; k < Lanes; k++)
        sum_p0[j] = sum_p0[j] + ternary_term(bus.w_in[2*(k*OutLen+j) +: 2],
                                             bus.vec_in[k*BitWidth +: BitWidth]);
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire)
      for (int j = 0; j < OutLen; j++) acc_p0[j] <= sum_p0[j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat <= '0;
    else if (in_fire) beat <= last_beat ? '0 : beat + BeatW'(1);
  end

  // ---- stage p1: output buffer, shifted toward element 0 on each consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < OutLen; j++) begin
        obuf_p1[j]     <= '0;
        obuf_sat_p1[j] <= 1'b0;
      end
    end else if (load) begin
      for (int j = 0; j < OutLen; j++) begin
        obuf_p1[j]     <= clip(sum_p0[j], bus.sat_en);
        obuf_sat_p1[j] <= out_of_range(sum_p0[j]);
      end
    end else if (out_fire) begin
      for (int j = 0; j < OutLen - 1; j++) begin
        obuf_p1[j]     <= obuf_p1[j+1];
        obuf_sat_p1[j] <= obuf_sat_p1[j+1];
      end
      obuf_p1[OutLen-1]     <= '0;
      obuf_sat_p1[OutLen-1] <= 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      EMPTY: if (load) begin
        state_n = DRAIN;
        idx_n   = '0;
      end
      DRAIN: if (out_fire) begin
        if (idx == LastIdx) begin
          state_n = load ? DRAIN : EMPTY;
          idx_n   = '0;
        end else begin
          idx_n = idx + IdxW'(1);
        end
      end
      default: state_n = EMPTY;
    endcase
    last_n = (state_n == DRAIN) && (idx_n == LastIdx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      idx         <= '0;
      out_last_p1 <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      out_last_p1 <= last_n;
    end
  end
endmodule

// File: tb/tb_ternary_matvec_stream.sv
// Directed self-checking bench for ternary_matvec_stream (14x7, 2 lanes, 8-bit).
module tb_ternary_matvec_stream;
  localparam int InLen = 14, OutLen = 7, BitWidth = 8, Lanes = 2, AccWidth = 12;
  localparam int Beats = InLen / Lanes;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ternary_matvec_stream_if #(.OutLen(OutLen), .BitWidth(BitWidth), .Lanes(Lanes)) bus();

  ternary_matvec_stream #(
    .InLen(InLen), .OutLen(OutLen), .BitWidth(BitWidth), .Lanes(Lanes), .AccWidth(AccWidth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         n_vec  = 0;
  int         n_fail = 0;
  int         xv [InLen];
  logic [1:0] wc [InLen][OutLen];
  logic [7:0] exp_d [OutLen];
  logic       exp_s [OutLen];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input bit sat);
    for (int j = 0; j < OutLen; j++) begin
      int s = 0;
      for (int i = 0; i < InLen; i++) begin
        if (wc[i][j] == 2'b01) s += xv[i];
        else if (wc[i][j] == 2'b11) s -= xv[i];
      end
      exp_s[j] = (s > 127) || (s < -128);
      if (sat && s > 127)       exp_d[j] = 8'h7f;
      else if (sat && s < -128) exp_d[j] = 8'h80;
      else                      exp_d[j] = 8'(s);
    end
  endfunction

  function automatic void fill_const(input int x, input logic [1:0] code);
    for (int i = 0; i < InLen; i++) begin
      xv[i] = x;
      for (int j = 0; j < OutLen; j++) wc[i][j] = code;
    end
  endfunction

  function automatic void fill_random();
    for (int i = 0; i < InLen; i++) begin
      xv[i] = int'($urandom_range(255, 0)) - 128;
      for (int j = 0; j < OutLen; j++) wc[i][j] = 2'($urandom_range(3, 0));
    end
  endfunction

  task automatic set_beat(input int b);
    for (int k = 0; k < Lanes; k++) begin
      bus.vec_in[k*BitWidth +: BitWidth] = 8'(xv[b*Lanes+k]);
      for (int j = 0; j < OutLen; j++)
        bus.w_in[2*(k*OutLen+j) +: 2] = wc[b*Lanes+k][j];
    end
  endtask

  task automatic drive_vector(input bit sat);
    for (int b = 0; b < Beats; b++) begin
      int n = 0;
      set_beat(b);
      bus.sat_en   = sat;
      bus.in_valid = 1'b1;
      #1;
      while (!bus.in_ready && n < 50) begin
        step();
        n++;
      end
      if (n == 50) begin
        n_vec++; n_fail++;
        $display("FAIL drive_vector beat %0d: in_ready got 0, need 1 within 50 cycles", b);
      end
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({bus.out_valid, bus.in_ready, bus.vec_out, bus.out_last, bus.out_sat} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_held: got v/r/d/l/s=%b/%b/%h/%b/%b need 0/1/00/0/0",
               bus.out_valid, bus.in_ready, bus.vec_out, bus.out_last, bus.out_sat);
    end
    step(); step();
    rst = 1'b0;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_release: got valid/ready=%b/%b need 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_vector();
    fill_const(1, 2'b01);
    bus.out_ready = 1'b0;
    drive_vector(1'b1);
    for (int b = 0; b < 3; b++) begin
      set_beat(b);
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.in_ready, bus.vec_out} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_reset: got valid/ready/data=%b/%b/%h need 0/1/00",
               bus.out_valid, bus.in_ready, bus.vec_out);
    end
    #1 rst = 1'b0;
    step();
    model(1'b1);
    drive_vector(1'b1);
    bus.out_ready = 1'b1;
    for (int j = 0; j < OutLen; j++) begin
      n_vec++;
      if ({bus.out_valid, bus.vec_out, bus.out_sat, bus.out_last} !== {1'b1, 8'd14, 1'b0, j == OutLen-1}) begin
        n_fail++;
        $display("FAIL mid_reset_result[%0d]: got v/d/s/l=%b/%h/%b/%b need 1/0e/0/%b",
                 j, bus.out_valid, bus.vec_out, bus.out_sat, bus.out_last, j == OutLen-1);
      end
      step();
    end
  endtask

  task automatic check_drain(input string name);
    bus.out_ready = 1'b1;
    for (int j = 0; j < OutLen; j++) begin
      n_vec++;
      if ({bus.out_valid, bus.vec_out, bus.out_sat, bus.out_last} !== {1'b1, exp_d[j], exp_s[j], j == OutLen-1}) begin
        n_fail++;
        $display("FAIL %s[%0d]: got v/d/s/l=%b/%h/%b/%b need 1/%h/%b/%b", name, j,
                 bus.out_valid, bus.vec_out, bus.out_sat, bus.out_last, exp_d[j], exp_s[j], j == OutLen-1);
      end
      step();
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_empty: got out_valid=%b need 0", name, bus.out_valid);
    end
  endtask

  task automatic test_saturation();
    fill_const(10, 2'b00);
    for (int i = 0; i < InLen; i++) wc[i][0] = 2'b01;
    model(1'b1);
    drive_vector(1'b1);
    check_drain("sat_clamp");
    model(1'b0);
    drive_vector(1'b0);
    check_drain("sat_wrap");
  endtask

  task automatic test_negation();
    fill_const(0, 2'b00);
    xv[0] = -128;
    wc[0][2] = 2'b11;
    model(1'b1);
    drive_vector(1'b1);
    check_drain("neg_min");
    wc[0][2] = 2'b10;
    model(1'b1);
    drive_vector(1'b1);
    check_drain("neg_code10");
  endtask

  task automatic test_mixed_signs();
    fill_const(0, 2'b00);
    for (int i = 0; i < InLen; i++) begin
      xv[i]    = (i % 2 == 0) ? -3 : 5;
      wc[i][1] = (i % 2 == 0) ? 2'b01 : 2'b11;
    end
    model(1'b1);
    drive_vector(1'b1);
    check_drain("mixed");
  endtask

  task automatic test_back_to_back();
    int         sx [4][InLen];
    logic [1:0] sw [4][InLen][OutLen];
    logic [8:0] q [$];
    logic [8:0] e;
    int  cyc = 0, got = 0, sent = 0;
    bit  started = 0;
    for (int v = 0; v < 4; v++) begin
      fill_random();
      model(v[0]);
      for (int j = 0; j < OutLen; j++) q.push_back({exp_s[j], exp_d[j]});
      for (int i = 0; i < InLen; i++) begin
        sx[v][i] = xv[i];
        for (int j = 0; j < OutLen; j++) sw[v][i][j] = wc[i][j];
      end
    end
    bus.out_ready = 1'b1;
    while (got < 4*OutLen && cyc < 80) begin
      if (sent < 4*Beats) begin
        int v = sent / Beats;
        for (int i = 0; i < InLen; i++) begin
          xv[i] = sx[v][i];
          for (int j = 0; j < OutLen; j++) wc[i][j] = sw[v][i][j];
        end
        set_beat(sent % Beats);
        bus.sat_en   = v[0];
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.in_valid) begin
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_in_ready beat %0d: got %b need 1", sent, bus.in_ready);
        end
      end
      if (started || bus.out_valid) begin
        started = 1;
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_gap at element %0d: got out_valid=%b need 1", got, bus.out_valid);
        end else begin
          e = q.pop_front();
          if ({bus.out_sat, bus.vec_out, bus.out_last} !== {e, got % OutLen == OutLen-1}) begin
            n_fail++;
            $display("FAIL stream_elem %0d: got s/d/l=%b/%h/%b need %b/%h/%b", got,
                     bus.out_sat, bus.vec_out, bus.out_last, e[8], e[7:0], got % OutLen == OutLen-1);
          end
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) sent++;
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (got != 4*OutLen) begin
      n_fail++;
      $display("FAIL stream_count: got %0d elements need %0d", got, 4*OutLen);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e1_d [OutLen];
    logic       e1_s [OutLen];
    bus.out_ready = 1'b0;
    fill_random();
    model(1'b1);
    drive_vector(1'b1);
    e1_d = exp_d;
    e1_s = exp_s;
    fill_random();
    model(1'b0);
    bus.sat_en = 1'b0;
    for (int c = 0; c < Beats + 2; c++) begin
      int b = (c < Beats) ? c : Beats - 1;
      set_beat(b);
      bus.in_valid = 1'b1;
      #1;
      n_vec++;
      if ({bus.in_ready, bus.out_valid, bus.vec_out} !== {b != Beats-1, 1'b1, e1_d[0]}) begin
        n_fail++;
        $display("FAIL bp_stall cycle %0d: got ready/valid/data=%b/%b/%h need %b/1/%h",
                 c, bus.in_ready, bus.out_valid, bus.vec_out, b != Beats-1, e1_d[0]);
      end
      step();
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < OutLen; j++) begin
      #1;
      n_vec++;
      if ({bus.in_ready, bus.out_valid, bus.vec_out, bus.out_sat} !== {j == OutLen-1, 1'b1, e1_d[j], e1_s[j]}) begin
        n_fail++;
        $display("FAIL bp_release[%0d]: got ready/valid/data/sat=%b/%b/%h/%b need %b/1/%h/%b",
                 j, bus.in_ready, bus.out_valid, bus.vec_out, bus.out_sat, j == OutLen-1, e1_d[j], e1_s[j]);
      end
      step();
    end
    bus.in_valid = 1'b0;
    check_drain("bp_vec2");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.vec_in    = '0;
    bus.w_in      = '0;
    bus.sat_en    = 1'b1;
    bus.out_ready = 1'b0;
    test_reset();
    test_reset_mid_vector();
    test_saturation();
    test_negation();
    test_mixed_signs();
    test_back_to_back();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
